// File: rtl/mem_dump_unit.sv
// mem_dump_unit
// Readback engine: on a start request it holds the CPU off the memory port,
// reads word_count consecutive words starting at a word-aligned address and
// streams each word out little-endian, one byte per valid/ready handshake.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start               dump request, only looked at while idle
//   start_addr          first byte address (low two bits ignored)
//   word_count          number of words to dump, 0 allowed
//   cpu_hold, busy      high while a dump is in progress (including the done cycle)
//   mem_re, mem_addr    one-cycle read strobe and word-aligned byte address
//   mem_rdata           synchronous read data, valid the cycle after mem_re
//   tx_data, tx_valid   output byte stream
//   tx_ready            byte accepted when tx_valid and tx_ready are both high
//   done                one-cycle pulse when a dump completes
module mem_dump_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              cpu_hold,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_WAIT = 3'd2,
        S_SEND = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [CNT_W-1:0]  left_r;
    logic [1:0]        byte_idx_r;
    logic [DATA_W-1:0] word_r;
    logic [7:0]        tx_data_r;
    logic              tx_valid_r;
    logic              mem_re_r;
    logic              done_r;

    logic [ADDR_W-1:0] aligned_addr_s;
    logic [ADDR_W-1:0] addr_inc_s;
    logic              handshake_s;
    logic              last_word_s;

    // Little-endian byte lane select of a memory word.
    function automatic logic [7:0] select_byte(input logic [DATA_W-1:0] w,
                                               input logic [1:0]        idx);
        case (idx)
            2'd0:    select_byte = w[7:0];
            2'd1:    select_byte = w[15:8];
            2'd2:    select_byte = w[23:16];
            default: select_byte = w[31:24];
        endcase
    endfunction

    // Masking (rather than slicing) keeps every start_addr bit in use.
    assign aligned_addr_s = start_addr & {{(ADDR_W-2){1'b1}}, 2'b00};
    // Address increment wraps naturally modulo 2^ADDR_W.
    assign addr_inc_s     = addr_r + ADDR_W'(3'd4);
    assign handshake_s    = tx_valid_r & tx_ready;
    assign last_word_s    = (left_r == CNT_W'(1'b1));

    // Main sequencer: state, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= S_IDLE;
            addr_r     <= {ADDR_W{1'b0}};
            left_r     <= {CNT_W{1'b0}};
            byte_idx_r <= 2'd0;
            word_r     <= {DATA_W{1'b0}};
            tx_data_r  <= 8'd0;
            tx_valid_r <= 1'b0;
            mem_re_r   <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        if (word_count != {CNT_W{1'b0}}) begin
                            addr_r   <= aligned_addr_s;
                            left_r   <= word_count;
                            mem_re_r <= 1'b1;
                            state_r  <= S_ADDR;
                        end else begin
                            // Empty dump: straight to the done cycle, no reads.
                            done_r  <= 1'b1;
                            state_r <= S_FIN;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_ADDR: begin
                    mem_re_r <= 1'b0;
                    state_r  <= S_WAIT;
                end
                S_WAIT: begin
                    // Read data is valid this cycle; present byte 0 next cycle.
                    word_r     <= mem_rdata;
                    byte_idx_r <= 2'd0;
                    tx_data_r  <= select_byte(mem_rdata, 2'd0);
                    tx_valid_r <= 1'b1;
                    state_r    <= S_SEND;
                end
                S_SEND: begin
                    if (handshake_s) begin
                        if (byte_idx_r != 2'd3) begin
                            byte_idx_r <= byte_idx_r + 2'd1;
                            tx_data_r  <= select_byte(word_r, byte_idx_r + 2'd1);
                            state_r    <= S_SEND;
                        end else begin
                            tx_valid_r <= 1'b0;
                            left_r     <= left_r - CNT_W'(1'b1);
                            addr_r     <= addr_inc_s;
                            if (last_word_s) begin
                                done_r  <= 1'b1;
                                state_r <= S_FIN;
                            end else begin
                                mem_re_r <= 1'b1;
                                state_r  <= S_ADDR;
                            end
                        end
                    end else begin
                        state_r <= S_SEND;
                    end
                end
                S_FIN: begin
                    done_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    tx_valid_r <= 1'b0;
                    mem_re_r   <= 1'b0;
                    done_r     <= 1'b0;
                    state_r    <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = (state_r != S_IDLE);
    assign cpu_hold = (state_r != S_IDLE);
    assign mem_re   = mem_re_r;
    assign mem_addr = addr_r;
    assign tx_data  = tx_data_r;
    assign tx_valid = tx_valid_r;
    assign done     = done_r;

endmodule
